// File: rtl/piece_redraw_seq.sv
// piece_redraw_seq: incremental redraw sequencer between game logic and the
// box painter. It erases the previous piece footprint, draws the new one and
// runs full-board clears, one painter job at a time over start/busy/done.
// Optional feature macro: REDRAW_SKIP_OVERLAP_EN (skip erase/draw of cells
// shared by the old and new footprint).
module piece_redraw_seq #(
    parameter int unsigned NCELLS         = 4,
    parameter int unsigned COLS           = 10,
    parameter int unsigned ROWS           = 20,
    parameter int unsigned CELL_W         = 64,
    parameter int unsigned CELL_H         = 24,
    parameter int unsigned XW             = 10,
    parameter int unsigned YW             = 9,
    parameter int unsigned CW             = 9,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   clear_req_i,
    input  logic                   update_req_i,
    input  logic [4*NCELLS-1:0]    cur_x_i,
    input  logic [5*NCELLS-1:0]    cur_y_i,
    input  logic [NCELLS-1:0]      cur_valid_i,
    input  logic [CW-1:0]          piece_color_i,
    input  logic [CW-1:0]          bg_color_i,
    input  logic                   paint_busy_i,
    input  logic                   paint_done_i,
    output logic                   paint_start_o,
    output logic [XW-1:0]          paint_x0_o,
    output logic [YW-1:0]          paint_y0_o,
    output logic [CW-1:0]          paint_color_o,
    output logic                   seq_busy_o,
    output logic                   frame_done_o
);

    localparam int unsigned CXW = 4;
    localparam int unsigned RYW = 5;
    localparam int unsigned IW  = (NCELLS > 1) ? $clog2(NCELLS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLR_ISSUE,
        CLR_WAIT,
        ER_ISSUE,
        ER_WAIT,
        DR_ISSUE,
        DR_WAIT,
        COMMIT
    } state_t;

    state_t                  state_q;
    logic [CXW*NCELLS-1:0]   prev_x_q;
    logic [RYW*NCELLS-1:0]   prev_y_q;
    logic [NCELLS-1:0]       prev_valid_q;
    logic [CXW*NCELLS-1:0]   new_x_q;
    logic [RYW*NCELLS-1:0]   new_y_q;
    logic [NCELLS-1:0]       new_valid_q;
    logic [IW-1:0]           idx_q;
    logic [CXW-1:0]          clr_x_q;
    logic [RYW-1:0]          clr_y_q;
    logic                    pend_upd_q;
    logic                    pend_clr_q;
    logic                    paint_start_q;
    logic [XW-1:0]           paint_x0_q;
    logic [YW-1:0]           paint_y0_q;
    logic [CW-1:0]           paint_color_q;
    logic                    seq_busy_q;
    logic                    frame_done_q;

    logic [CXW-1:0]          er_col_c;
    logic [RYW-1:0]          er_row_c;
    logic                    er_valid_c;
    logic                    er_overlap_c;
    logic                    er_job_c;
    logic [CXW-1:0]          dr_col_c;
    logic [RYW-1:0]          dr_row_c;
    logic                    dr_valid_c;
    logic                    dr_overlap_c;
    logic                    dr_job_c;
    logic                    idx_last_c;
    logic                    clr_last_c;
    logic                    can_issue_c;

    function automatic logic [XW-1:0] col_to_x(input logic [CXW-1:0] col);
        return XW'(32'(col) * CELL_W);
    endfunction

    function automatic logic [YW-1:0] row_to_y(input logic [RYW-1:0] row);
        return YW'(32'(row) * CELL_H);
    endfunction

    // Select the cell under idx from both footprints and decide whether it needs a job.
    always_comb begin
        er_col_c     = '0;
        er_row_c     = '0;
        er_valid_c   = 1'b0;
        er_overlap_c = 1'b0;
        dr_col_c     = '0;
        dr_row_c     = '0;
        dr_valid_c   = 1'b0;
        dr_overlap_c = 1'b0;
        for (int i = 0; i < int'(NCELLS); i++) begin
            if (idx_q == IW'(i)) begin
                er_col_c   = prev_x_q[CXW*i +: CXW];
                er_row_c   = prev_y_q[RYW*i +: RYW];
                er_valid_c = prev_valid_q[i];
                dr_col_c   = new_x_q[CXW*i +: CXW];
                dr_row_c   = new_y_q[RYW*i +: RYW];
                dr_valid_c = new_valid_q[i];
            end
        end
`ifdef REDRAW_SKIP_OVERLAP_EN
        // A cell present in both footprints already shows the piece colour.
        for (int j = 0; j < int'(NCELLS); j++) begin
            if (new_valid_q[j] && (new_x_q[CXW*j +: CXW] == er_col_c)
                               && (new_y_q[RYW*j +: RYW] == er_row_c)) begin
                er_overlap_c = 1'b1;
            end
            if (prev_valid_q[j] && (prev_x_q[CXW*j +: CXW] == dr_col_c)
                                && (prev_y_q[RYW*j +: RYW] == dr_row_c)) begin
                dr_overlap_c = 1'b1;
            end
        end
`endif
        er_job_c = er_valid_c && (32'(er_col_c) < COLS) && (32'(er_row_c) < ROWS)
                   && !er_overlap_c;
        dr_job_c = dr_valid_c && (32'(dr_col_c) < COLS) && (32'(dr_row_c) < ROWS)
                   && !dr_overlap_c;
        idx_last_c  = (idx_q == IW'(NCELLS - 1));
        clr_last_c  = (clr_x_q == CXW'(COLS - 1)) && (clr_y_q == RYW'(ROWS - 1));
        can_issue_c = !paint_busy_i && !paint_start_q;
    end

    // Sequencer state, footprints, counters, pending flags and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            prev_x_q      <= '0;
            prev_y_q      <= '0;
            prev_valid_q  <= '0;
            new_x_q       <= '0;
            new_y_q       <= '0;
            new_valid_q   <= '0;
            idx_q         <= '0;
            clr_x_q       <= '0;
            clr_y_q       <= '0;
            pend_upd_q    <= 1'b0;
            pend_clr_q    <= (CLEAR_ON_RESET != 0);
            paint_start_q <= 1'b0;
            paint_x0_q    <= '0;
            paint_y0_q    <= '0;
            paint_color_q <= '0;
            seq_busy_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            paint_start_q <= 1'b0;
            frame_done_q  <= 1'b0;

            // Requests seen mid-sequence are parked until the next IDLE.
            if (state_q != IDLE) begin
                if (update_req_i) pend_upd_q <= 1'b1;
                if (clear_req_i)  pend_clr_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pend_clr_q || clear_req_i) begin
                        pend_clr_q   <= 1'b0;
                        pend_upd_q   <= 1'b0;
                        prev_valid_q <= '0;
                        clr_x_q      <= '0;
                        clr_y_q      <= '0;
                        seq_busy_q   <= 1'b1;
                        state_q      <= CLR_ISSUE;
                    end else if (pend_upd_q || update_req_i) begin
                        pend_upd_q  <= 1'b0;
                        new_x_q     <= cur_x_i;
                        new_y_q     <= cur_y_i;
                        new_valid_q <= cur_valid_i;
                        idx_q       <= '0;
                        seq_busy_q  <= 1'b1;
                        state_q     <= ER_ISSUE;
                    end
                end

                CLR_ISSUE: begin
                    if (can_issue_c) begin
                        paint_start_q <= 1'b1;
                        paint_x0_q    <= col_to_x(clr_x_q);
                        paint_y0_q    <= row_to_y(clr_y_q);
                        paint_color_q <= bg_color_i;
                        state_q       <= CLR_WAIT;
                    end
                end

                CLR_WAIT: begin
                    if (paint_done_i) begin
                        if (clr_last_c) begin
                            new_x_q     <= cur_x_i;
                            new_y_q     <= cur_y_i;
                            new_valid_q <= cur_valid_i;
                            idx_q       <= '0;
                            state_q     <= DR_ISSUE;
                        end else begin
                            if (clr_x_q == CXW'(COLS - 1)) begin
                                clr_x_q <= '0;
                                clr_y_q <= clr_y_q + RYW'(1);
                            end else begin
                                clr_x_q <= clr_x_q + CXW'(1);
                            end
                            state_q <= CLR_ISSUE;
                        end
                    end
                end

                ER_ISSUE: begin
                    if (!er_job_c) begin
                        idx_q   <= idx_last_c ? '0 : idx_q + IW'(1);
                        state_q <= idx_last_c ? DR_ISSUE : ER_ISSUE;
                    end else if (can_issue_c) begin
                        paint_start_q <= 1'b1;
                        paint_x0_q    <= col_to_x(er_col_c);
                        paint_y0_q    <= row_to_y(er_row_c);
                        paint_color_q <= bg_color_i;
                        state_q       <= ER_WAIT;
                    end
                end

                ER_WAIT: begin
                    if (paint_done_i) begin
                        idx_q   <= idx_last_c ? '0 : idx_q + IW'(1);
                        state_q <= idx_last_c ? DR_ISSUE : ER_ISSUE;
                    end
                end

                DR_ISSUE: begin
                    if (!dr_job_c) begin
                        idx_q   <= idx_last_c ? '0 : idx_q + IW'(1);
                        state_q <= idx_last_c ? COMMIT : DR_ISSUE;
                    end else if (can_issue_c) begin
                        paint_start_q <= 1'b1;
                        paint_x0_q    <= col_to_x(dr_col_c);
                        paint_y0_q    <= row_to_y(dr_row_c);
                        paint_color_q <= piece_color_i;
                        state_q       <= DR_WAIT;
                    end
                end

                DR_WAIT: begin
                    if (paint_done_i) begin
                        idx_q   <= idx_last_c ? '0 : idx_q + IW'(1);
                        state_q <= idx_last_c ? COMMIT : DR_ISSUE;
                    end
                end

                COMMIT: begin
                    prev_x_q     <= new_x_q;
                    prev_y_q     <= new_y_q;
                    prev_valid_q <= new_valid_q;
                    frame_done_q <= 1'b1;
                    seq_busy_q   <= 1'b0;
                    state_q      <= IDLE;
                end

                default: begin
                    seq_busy_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign paint_start_o = paint_start_q;
    assign paint_x0_o    = paint_x0_q;
    assign paint_y0_o    = paint_y0_q;
    assign paint_color_o = paint_color_q;
    assign seq_busy_o    = seq_busy_q;
    assign frame_done_o  = frame_done_q;

endmodule

// File: tb/tb_piece_redraw_seq.sv
// Bench for piece_redraw_seq: painter model with latency 3, job scoreboard,
// table of redraw vectors and hand sequences for clear, coalescing and reset.
module tb_piece_redraw_seq;

    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;
    localparam int unsigned CW = 9;
    localparam int          L  = 3;
`ifdef REDRAW_SKIP_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif
    localparam logic [CW-1:0] PC = 9'h1C0;
    localparam logic [CW-1:0] BG = 9'h005;

    logic          clk = 1'b0;
    logic          resetn;
    logic          clear_req, update_req;
    logic [15:0]   cur_x;
    logic [19:0]   cur_y;
    logic [3:0]    cur_valid;
    logic          paint_busy = 1'b0;
    logic          paint_done = 1'b0;
    logic          paint_start;
    logic [XW-1:0] paint_x0;
    logic [YW-1:0] paint_y0;
    logic [CW-1:0] paint_color;
    logic          seq_busy, frame_done;

    always #10 clk = ~clk;

    piece_redraw_seq dut (
        .CLOCK_50      (clk),
        .resetn        (resetn),
        .clear_req_i   (clear_req),
        .update_req_i  (update_req),
        .cur_x_i       (cur_x),
        .cur_y_i       (cur_y),
        .cur_valid_i   (cur_valid),
        .piece_color_i (PC),
        .bg_color_i    (BG),
        .paint_busy_i  (paint_busy),
        .paint_done_i  (paint_done),
        .paint_start_o (paint_start),
        .paint_x0_o    (paint_x0),
        .paint_y0_o    (paint_y0),
        .paint_color_o (paint_color),
        .seq_busy_o    (seq_busy),
        .frame_done_o  (frame_done)
    );

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } job_t;

    typedef struct {
        logic [15:0] x;
        logic [19:0] y;
        logic [3:0]  v;
        int          exp_plain;
        int          exp_ovl;
        int          lat_plain;
        int          lat_ovl;
    } vec_t;

    job_t  sb[$];
    vec_t  vecs[7];
    int    checks = 0, errors = 0;
    int    job_cnt = 0, frame_cnt = 0, cyc = 0;
    int    first_lat = -1, req_cyc = 0, pcnt = 0;
    bit    arm = 1'b0, hold_ok = 1'b0, busy_s;
    job_t  cur_job, exp_job;
    logic [15:0] pm_x;
    logic [19:0] pm_y;
    logic [3:0]  pm_v;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Painter model and output monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        busy_s = paint_busy;
        if (resetn && frame_done) frame_cnt++;
        paint_done = 1'b0;
        if (paint_busy) begin
            pcnt--;
            if (pcnt == 0) begin
                paint_busy = 1'b0;
                paint_done = 1'b1;
                if (hold_ok && resetn)
                    chk("job_hold", int'({paint_x0, paint_y0, paint_color}), int'(cur_job));
                hold_ok = 1'b0;
            end
        end
        if (resetn && paint_start) begin
            chk("start_while_busy", int'(busy_s), 0);
            job_cnt++;
            if (arm) begin
                first_lat = cyc - req_cyc;
                arm = 1'b0;
            end
            cur_job = {paint_x0, paint_y0, paint_color};
            if (sb.size() == 0) begin
                chk("unexpected_job", int'(cur_job), -1);
            end else begin
                exp_job = sb.pop_front();
                chk($sformatf("job_%0d", job_cnt), int'(cur_job), int'(exp_job));
            end
            hold_ok    = 1'b1;
            paint_busy = 1'b1;
            pcnt       = L;
        end
        if (!resetn) hold_ok = 1'b0;
    end

    function automatic bit in_rng(input logic [3:0] col, input logic [4:0] row);
        return (col < 4'd10) && (row < 5'd20);
    endfunction

    task automatic push_job(input logic [3:0] col, input logic [4:0] row, input logic [CW-1:0] c);
        job_t j;
        j.x = XW'(int'(col) * 64);
        j.y = YW'(int'(row) * 24);
        j.c = c;
        sb.push_back(j);
    endtask

    // Expected jobs for one redraw from the model's committed footprint.
    task automatic model_redraw(input logic [15:0] nx, input logic [19:0] ny, input logic [3:0] nv);
        bit skip;
        for (int i = 0; i < 4; i++) begin
            skip = 1'b0;
            for (int j = 0; j < 4; j++)
                if (OVL && nv[j] && nx[4*j +: 4] == pm_x[4*i +: 4] && ny[5*j +: 5] == pm_y[5*i +: 5])
                    skip = 1'b1;
            if (pm_v[i] && in_rng(pm_x[4*i +: 4], pm_y[5*i +: 5]) && !skip)
                push_job(pm_x[4*i +: 4], pm_y[5*i +: 5], BG);
        end
        for (int i = 0; i < 4; i++) begin
            skip = 1'b0;
            for (int j = 0; j < 4; j++)
                if (OVL && pm_v[j] && pm_x[4*j +: 4] == nx[4*i +: 4] && pm_y[5*j +: 5] == ny[5*i +: 5])
                    skip = 1'b1;
            if (nv[i] && in_rng(nx[4*i +: 4], ny[5*i +: 5]) && !skip)
                push_job(nx[4*i +: 4], ny[5*i +: 5], PC);
        end
        pm_x = nx; pm_y = ny; pm_v = nv;
    endtask

    // Expected jobs for a full clear followed by the draw of the snapshot.
    task automatic model_clear(input logic [15:0] nx, input logic [19:0] ny, input logic [3:0] nv);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                push_job(4'(c), 5'(r), BG);
        for (int i = 0; i < 4; i++)
            if (nv[i] && in_rng(nx[4*i +: 4], ny[5*i +: 5]))
                push_job(nx[4*i +: 4], ny[5*i +: 5], PC);
        pm_x = nx; pm_y = ny; pm_v = nv;
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        int n = 0;
        while (frame_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frame_cnt < target) chk({name, "_timeout"}, frame_cnt, target);
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update_req = 1'b1;
        first_lat  = -1;
        arm        = 1'b1;
        req_cyc    = cyc;
        @(negedge clk);
        update_req = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_start"}, int'(paint_start), 0);
        chk({tag, "_x0"},    int'(paint_x0), 0);
        chk({tag, "_y0"},    int'(paint_y0), 0);
        chk({tag, "_color"}, int'(paint_color), 0);
        chk({tag, "_busy"},  int'(seq_busy), 0);
        chk({tag, "_frame"}, int'(frame_done), 0);
    endtask

    task automatic run_vec(input int k);
        int j0, f0, exp, lat;
        cur_x = vecs[k].x; cur_y = vecs[k].y; cur_valid = vecs[k].v;
        model_redraw(vecs[k].x, vecs[k].y, vecs[k].v);
        exp = OVL ? vecs[k].exp_ovl : vecs[k].exp_plain;
        lat = OVL ? vecs[k].lat_ovl : vecs[k].lat_plain;
        j0 = job_cnt; f0 = frame_cnt;
        pulse_update();
        wait_frames($sformatf("v%0d", k), f0 + 1, 400);
        chk($sformatf("v%0d_jobs", k), job_cnt - j0, exp);
        chk($sformatf("v%0d_sb_empty", k), sb.size(), 0);
        chk($sformatf("v%0d_idle", k), int'(seq_busy), 0);
        if (lat >= 0) chk($sformatf("v%0d_first_start_lat", k), first_lat, lat);
    endtask

    initial begin
        int j0, f0, n;
        vecs[0] = '{{4'd6,4'd5,4'd6,4'd5},  {5'd1,5'd1,5'd0,5'd0},     4'b1111, 8, 4, 2,  2};
        vecs[1] = '{{4'd2,4'd3,4'd9,4'd0},  {5'd2,5'd20,5'd19,5'd19},  4'b0011, 6, 6, 2,  2};
        vecs[2] = '{{4'd12,4'd3,4'd9,4'd0}, {5'd5,5'd20,5'd19,5'd19},  4'b1111, 4, 0, 2, -1};
        vecs[3] = '{{4'd5,4'd4,4'd5,4'd4},  {5'd1,5'd1,5'd0,5'd0},     4'b1111, 6, 6, 2,  2};
        vecs[4] = '{{4'd5,4'd4,4'd5,4'd4},  {5'd1,5'd1,5'd0,5'd0},     4'b1111, 8, 0, 2, -1};
        vecs[5] = '{{4'd5,4'd4,4'd5,4'd4},  {5'd1,5'd1,5'd0,5'd0},     4'b0000, 4, 4, 2,  2};
        vecs[6] = '{{4'd2,4'd1,4'd2,4'd1},  {5'd2,5'd2,5'd1,5'd1},     4'b1111, 4, 4, 6,  6};

        resetn = 1'b0; clear_req = 1'b0; update_req = 1'b0;
        cur_x = {4'd5,4'd4,4'd5,4'd4}; cur_y = {5'd1,5'd1,5'd0,5'd0}; cur_valid = 4'b1111;
        pm_x = '0; pm_y = '0; pm_v = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("rst");

        // Automatic clear after reset release: 200 background jobs then the piece.
        model_clear(cur_x, cur_y, cur_valid);
        resetn = 1'b1;
        wait_frames("init", 1, 3000);
        chk("init_jobs", job_cnt, 204);
        chk("init_sb_empty", sb.size(), 0);
        chk("init_frames", frame_cnt, 1);

        for (int k = 0; k < 7; k++) run_vec(k);

        // Three extra requests during one redraw coalesce into one more sequence.
        f0 = frame_cnt;
        cur_x = {4'd4,4'd3,4'd4,4'd3}; cur_y = {5'd4,5'd4,5'd3,5'd3}; cur_valid = 4'b1111;
        model_redraw(cur_x, cur_y, cur_valid);
        model_redraw({4'd8,4'd7,4'd8,4'd7}, {5'd11,5'd11,5'd10,5'd10}, 4'b1111);
        pulse_update();
        cur_x = {4'd8,4'd7,4'd8,4'd7}; cur_y = {5'd11,5'd11,5'd10,5'd10};
        repeat (3) begin
            @(negedge clk); update_req = 1'b1;
            @(negedge clk); update_req = 1'b0;
        end
        wait_frames("coal", f0 + 2, 800);
        repeat (40) @(negedge clk);
        chk("coal_frames", frame_cnt, f0 + 2);
        chk("coal_sb_empty", sb.size(), 0);
        chk("coal_idle", int'(seq_busy), 0);

        // Clear and update in the same cycle: clear wins, no erase phase.
        f0 = frame_cnt; j0 = job_cnt;
        cur_x = vecs[6].x; cur_y = vecs[6].y; cur_valid = vecs[6].v;
        model_clear(cur_x, cur_y, cur_valid);
        @(negedge clk); clear_req = 1'b1; update_req = 1'b1;
        @(negedge clk); clear_req = 1'b0; update_req = 1'b0;
        wait_frames("clrupd", f0 + 1, 3000);
        repeat (20) @(negedge clk);
        chk("clrupd_frames", frame_cnt, f0 + 1);
        chk("clrupd_jobs", job_cnt - j0, 204);
        chk("clrupd_sb_empty", sb.size(), 0);
        chk("clrupd_idle", int'(seq_busy), 0);

        // Reset while the first erase is outstanding.
        j0 = job_cnt;
        push_job(4'd1, 5'd1, BG);
        cur_x = {4'd8,4'd7,4'd8,4'd7}; cur_y = {5'd11,5'd11,5'd10,5'd10}; cur_valid = 4'b1111;
        pulse_update();
        n = 0;
        while (job_cnt == j0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_first_erase", job_cnt - j0, 1);
        resetn = 1'b0;
        #1;
        check_outputs_zero("abort");
        chk("abort_sb_empty", sb.size(), 0);
        model_clear(cur_x, cur_y, cur_valid);
        @(negedge clk);
        resetn = 1'b1;
        f0 = frame_cnt; j0 = job_cnt;
        wait_frames("abort", f0 + 1, 3000);
        repeat (20) @(negedge clk);
        chk("abort_jobs", job_cnt - j0, 204);
        chk("abort_frames", frame_cnt, f0 + 1);
        chk("abort_sb_empty_end", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
